serial_adder: RTL and testbench

Bit-serial W-bit adder built around the one-bit full-adder stage (sum and carry cells). It accepts two W-bit operands on a start pulse and presents them LSB-first to the full-adder logic, one bit per clock. A registered carry closes the loop between bit slices. The sum bits are shifted into a result register, and a one-cycle done pulse is raised with the final sum and carry-out. It is the sequential driver stage that feeds the full adder and consumes its s/z outputs.

---
 rtl/serial_adder_if.sv | 25 ++
 rtl/serial_adder.sv | 103 ++++++++++
 tb/tb_serial_adder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// serial_adder_if -- request/result bundle for the bit-serial adder.
//   start, a, b, cin (and sub when SERIAL_ADDER_SUB_EN is defined) : requester -> adder
//   busy, done, s, cout                                            : adder -> requester
// Modports: master (requester side), slave (adder side).
interface serial_adder_if #(parameter int W = 8);
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
   logic         sub;
`endif
   logic         busy;
   logic         done;
   logic [W-1:0] s;
   logic         cout;

`ifdef SERIAL_ADDER_SUB_EN
   modport master (output start, a, b, cin, sub, input busy, done, s, cout);
   modport slave  (input start, a, b, cin, sub, output busy, done, s, cout);
`else
   modport master (output start, a, b, cin, input busy, done, s, cout);
   modport slave  (input start, a, b, cin, output busy, done, s, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder -- bit-serial W-bit adder. Operands are captured on an accepted
// start, fed LSB-first through a one-bit full-adder with a registered carry,
// and the sum bits are shifted into the result register from the MSB side.
// done pulses for one cycle with the final sum and carry-out, which then hold
// until the next accepted start.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_adder_if.slave (start/a/b/cin[/sub] in, busy/done/s/cout out)
// Optional feature: define SERIAL_ADDER_SUB_EN to compile in the sub input
// (subtract mode: B captured inverted, carry forced to 1).
module serial_adder #(
   parameter int W = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_adder_if.slave bus
);
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state, state_nxt;
   logic [W-1:0]  a_sh, b_sh, s_sh;
   logic          carry, cout_q;
   logic [CW-1:0] cnt;

   logic          accept, last;
   logic          fa_s, fa_c;
   logic [W-1:0]  b_in;
   logic          c_in;

   assign accept = (state == IDLE) && bus.start;
   assign last   = (cnt == CW'(W - 1));

   // one-bit full-adder slice on the current LSBs and the looped-back carry
   assign fa_s = a_sh[0] ^ b_sh[0] ^ carry;
   assign fa_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

`ifdef SERIAL_ADDER_SUB_EN
   // a - b = a + ~b + 1; cin is ignored when subtracting
   assign b_in = bus.sub ? ~bus.b : bus.b;
   assign c_in = bus.sub ? 1'b1   : bus.cin;
`else
   assign b_in = bus.b;
   assign c_in = bus.cin;
`endif

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (last)      state_nxt = DONE;
         DONE:                   state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // outputs decoded from state
   always_comb begin
      bus.busy = 1'b0;
      bus.done = 1'b0;
      case (state)
         RUN:     bus.busy = 1'b1;
         DONE:    begin bus.busy = 1'b1; bus.done = 1'b1; end
         default: ;
      endcase
   end

   // datapath: operand shifters, carry loop, result shifter, bit counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         s_sh   <= '0;
         carry  <= 1'b0;
         cout_q <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         a_sh  <= bus.a;
         b_sh  <= b_in;
         carry <= c_in;
         cnt   <= '0;
      end else if (state == RUN) begin
         a_sh  <= a_sh >> 1;
         b_sh  <= b_sh >> 1;
         s_sh  <= {fa_s, s_sh[W-1:1]};
         carry <= fa_c;
         cnt   <= cnt + CW'(1);
         if (last) cout_q <= fa_c;
      end
   end

   assign bus.s    = s_sh;
   assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder -- directed, table-driven bench for serial_adder (W=8).
// Compile with SERIAL_ADDER_SUB_EN defined to also cover subtract mode.
module tb_serial_adder;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   serial_adder_if #(.W(W)) bus ();

   serial_adder #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] exp_s;
      logic         exp_cout;
   } vec_t;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic st, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
      bus.start = st;
      bus.a     = a;
      bus.b     = b;
      bus.cin   = cin;
`ifdef SERIAL_ADDER_SUB_EN
      bus.sub   = sub;
`else
      if (sub) $display("note: sub ignored in add-only build");
`endif
   endtask

   // one start pulse, then watch done/busy edge by edge (bounded)
   task automatic run_op(input string nm, input vec_t v);
      int done_at, done_cnt, busy_cnt;
      logic [W-1:0] s_done;
      logic c_done;
      done_at = -1; done_cnt = 0; busy_cnt = 0; s_done = 'x; c_done = 1'bx;
      @(negedge clk);
      drive(1'b1, v.a, v.b, v.cin, v.sub);
      @(posedge clk); #1;                       // E0
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      if (bus.busy) busy_cnt++;
      for (int n = 1; n <= W + 3; n++) begin
         @(posedge clk); #1;
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = n; s_done = bus.s; c_done = bus.cout;
            end
         end
      end
      check({nm, " done_edge"}, done_at, W);
      check({nm, " done_cnt"}, done_cnt, 1);
      check({nm, " busy_cycles"}, busy_cnt, W + 1);
      check({nm, " s"}, s_done, v.exp_s);
      check({nm, " cout"}, c_done, v.exp_cout);
      check({nm, " s_hold"}, bus.s, v.exp_s);
   endtask

   vec_t vecs[8];

   initial begin
      int d1, d2, dcnt;
      logic [W-1:0] s1, s2;
      logic c2;
      vec_t v;

      vecs[0] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1};
      vecs[3] = '{8'h3C, 8'h12, 1'b0, 1'b0, 8'h4E, 1'b0};
      vecs[4] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1};
      vecs[5] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1};
      vecs[6] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0};
      vecs[7] = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0};

      drive(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      check("rst busy", bus.busy, 0);
      check("rst done", bus.done, 0);
      check("rst s", bus.s, 0);
      check("rst cout", bus.cout, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) run_op($sformatf("vec%0d", i), vecs[i]);

      // start held high: accepted only at IDLE edges; mid-RUN operand change ignored
      d1 = -1; d2 = -1; dcnt = 0; s1 = 'x; s2 = 'x; c2 = 1'bx;
      @(negedge clk);
      drive(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
      @(posedge clk); #1;
      for (int n = 1; n <= 19; n++) begin
         @(posedge clk); #1;
         if (n == 3) drive(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
         if (bus.done) begin
            dcnt++;
            if (d1 < 0) begin d1 = n; s1 = bus.s; end
            else if (d2 < 0) begin d2 = n; s2 = bus.s; c2 = bus.cout; end
         end
      end
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      check("hold done1_edge", d1, 8);
      check("hold done2_edge", d2, 18);
      check("hold done_cnt", dcnt, 2);
      check("hold s1", s1, 8'h33);
      check("hold s2", s2, 8'hFE);
      check("hold cout2", c2, 1);
      repeat (3) @(posedge clk);
      #1 check("hold idle", bus.busy, 0);

      // reset 4 cycles into RUN, with a nonzero previous result in s
      run_op("pre_rst", vecs[7]);
      @(negedge clk);
      drive(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
      @(posedge clk); #1;
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort busy", bus.busy, 0);
      check("abort done", bus.done, 0);
      check("abort s", bus.s, 0);
      check("abort cout", bus.cout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      dcnt = 0;
      for (int n = 0; n < 12; n++) begin
         @(posedge clk); #1;
         if (bus.done || bus.busy) dcnt++;
      end
      check("abort no_done", dcnt, 0);
      v = '{8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0};
      run_op("post_rst", v);

`ifdef SERIAL_ADDER_SUB_EN
      v = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0};
      run_op("sub_5m7", v);
      v = '{8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1};
      run_op("sub_7m5", v);
      v = '{8'h3C, 8'h12, 1'b0, 1'b0, 8'h4E, 1'b0};
      run_op("sub0_add", v);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end
endmodule
